// File: rtl/banked_sram_pkg.sv
// Shared types and helpers for the banked burst SRAM: FSM state encoding,
// address-width derivation and the parity function used when parity is built in.
package banked_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic int unsigned addr_w(input int unsigned bank_w, input int unsigned lo_w);
        return bank_w + lo_w;
    endfunction

    // Even parity over a zero-extended word; callers cast their data to 64 bits.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous storage array with registered read data.
// Kept separate so a hard macro can drop in without touching the control logic.
module sram_array #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Read port holds its last value between reads so a stalled beat stays stable.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_sram_burst.sv
// Banked single-port SRAM with a valid/ready command channel and burst streams.
// Optional parity storage and checking is built in when BANKED_SRAM_PARITY_EN is defined.
module banked_sram_burst
    import banked_sram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LO_W   = 6,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic              cmd_bank_sel,
    input  logic [BANK_W-1:0] cmd_bank,
    input  logic [LO_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [BANK_W-1:0] bank_q,
`ifdef BANKED_SRAM_PARITY_EN
    input  logic              err_inj,
    output logic              rd_perr,
`endif
    output logic              busy
);

    localparam int unsigned ADDR_W = addr_w(BANK_W, LO_W);
`ifdef BANKED_SRAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    state_e              state_q, state_d;
    logic [BANK_W-1:0]   bank_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d, ptr_inc;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                rd_valid_q, rd_valid_d;
    logic [BANK_W-1:0]   cmd_bank_eff;
    logic                mem_en, mem_we;
    logic [MEM_W-1:0]    mem_wdata, mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bank_q     <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Offset wraps inside the bank; the bank bits never change mid-burst.
    assign ptr_inc      = {ptr_q[ADDR_W-1:LO_W], ptr_q[LO_W-1:0] + LO_W'(1)};
    assign cmd_bank_eff = cmd_bank_sel ? cmd_bank : bank_q;

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bank_sel) begin
                        bank_d = cmd_bank;
                    end
                    ptr_d   = {cmd_bank_eff, cmd_addr};
                    rem_d   = cmd_len;
                    state_d = cmd_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    ptr_d  = ptr_inc;
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            READ: begin
                // Issue only when the output register is free or being drained this cycle.
                if (!rd_valid_q || rd_ready) begin
                    mem_en     = 1'b1;
                    rd_valid_d = 1'b1;
                    ptr_d      = ptr_inc;
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BANKED_SRAM_PARITY_EN
    assign mem_wdata = {even_parity(64'(wr_data)) ^ err_inj, wr_data};
    assign rd_perr   = ^mem_rdata;
`else
    assign mem_wdata = wr_data;
`endif

    sram_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en && !rst),
        .we    (mem_we),
        .addr  (ptr_q),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rd_data   = mem_rdata[DATA_W-1:0];
    assign rd_valid  = rd_valid_q;
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign wr_ready  = (state_q == WRITE) && !rst;
    assign busy      = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_banked_sram_burst.sv
// Scoreboard bench for banked_sram_burst: a flat-array memory model predicts read
// beats, a negedge monitor pops and compares them. Covers BANKED_SRAM_PARITY_EN when defined.
module tb_banked_sram_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic       cmd_bank_sel = 1'b0;
    logic [2:0] cmd_bank = 3'd0;
    logic [5:0] cmd_addr = 6'd0;
    logic [5:0] cmd_len = 6'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'd0;
    logic       rd_valid;
    logic       rd_ready = 1'b1;
    logic [7:0] rd_data;
    logic [2:0] bank_q;
    logic       busy;
`ifdef BANKED_SRAM_PARITY_EN
    logic       err_inj = 1'b0;
    logic       rd_perr;
`endif

    banked_sram_burst dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_bank_sel (cmd_bank_sel),
        .cmd_bank     (cmd_bank),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .bank_q       (bank_q),
`ifdef BANKED_SRAM_PARITY_EN
        .err_inj      (err_inj),
        .rd_perr      (rd_perr),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } exp_t;

    logic [7:0] model_mem  [512];
    logic       model_perr [512];
    logic [2:0] model_bank = 3'd0;
    exp_t       exp_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int rd_mode     = 0;
    int pat         = 0;
    bit wr_rand     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read back-pressure: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        pat = pat + 1;
        case (rd_mode)
            1:       rd_ready = (pat % 4 == 0) || (pat % 4 == 3);
            2:       rd_ready = 1'($urandom % 2);
            default: rd_ready = 1'b1;
        endcase
    end

    // Monitor: pops expected beats on each read handshake and checks stream rules.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(rd_valid), 1);
                check("stall_data", 32'(rd_data), 32'(prev_data));
            end
            if (cmd_ready || wr_ready)
                check("ready_exclusive", 32'(cmd_ready & wr_ready), 0);
            if (rd_valid || exp_q.size() != 0)
                check("cmd_ready_pending", 32'(cmd_ready), 0);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_unexpected: got beat 0x%0h, expected none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e.data));
`ifdef BANKED_SRAM_PARITY_EN
                    check("rd_perr", 32'(rd_perr), 32'(e.perr));
`endif
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    // Called at a negedge; returns at the negedge after the command handshake.
    task automatic send_cmd(input bit we, input bit sel, input logic [2:0] bank,
                            input logic [5:0] addr, input logic [5:0] len,
                            output logic [2:0] eff_bank);
        int n = 0;
        cmd_we = we; cmd_bank_sel = sel; cmd_bank = bank; cmd_addr = addr; cmd_len = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 1);
        if (sel) model_bank = bank;
        eff_bank = model_bank;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bank_q", 32'(bank_q), 32'(model_bank));
        check("busy_after_cmd", 32'(busy), 1);
    endtask

    task automatic write_burst(input bit sel, input logic [2:0] bank, input logic [5:0] addr,
                               input logic [5:0] len, input bit rnd, input logic [7:0] base,
                               input bit inj);
        logic [2:0] b;
        logic [7:0] d;
        int a, n;
        bit done;
        send_cmd(1'b1, sel, bank, addr, len, b);
`ifdef BANKED_SRAM_PARITY_EN
        err_inj = inj;
`endif
        for (int i = 0; i <= int'(len); i++) begin
            d = rnd ? 8'($urandom) : 8'(32'(base) + i);
            n = 0;
            done = 1'b0;
            while (!done) begin
                wr_valid = wr_rand ? 1'($urandom % 2) : 1'b1;
                wr_data  = d;
                if (wr_valid && wr_ready) begin
                    a = int'(b) * 64 + (int'(addr) + i) % 64;
                    model_mem[a]  = d;
                    model_perr[a] = inj;
                    done = 1'b1;
                end else if (++n > 200) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wr_timeout: got wr_ready=%0b, expected 1", wr_ready);
                    done = 1'b1;
                end
                @(negedge clk);
            end
        end
        wr_valid = 1'b0;
`ifdef BANKED_SRAM_PARITY_EN
        err_inj = 1'b0;
`endif
        check("busy_after_write", 32'(busy), 0);
        check("cmd_ready_after_write", 32'(cmd_ready), 1);
    endtask

    task automatic read_burst(input bit sel, input logic [2:0] bank, input logic [5:0] addr,
                              input logic [5:0] len, input int mode);
        logic [2:0] b;
        int a, n;
        rd_mode = mode;
        send_cmd(1'b0, sel, bank, addr, len, b);
        for (int i = 0; i <= int'(len); i++) begin
            a = int'(b) * 64 + (int'(addr) + i) % 64;
            exp_q.push_back({model_perr[a], model_mem[a]});
        end
        check("rd_latency_edge1", 32'(rd_valid), 0);
        @(negedge clk);
        check("rd_latency_edge2", 32'(rd_valid), 1);
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rd_beats_left", 32'(exp_q.size()), 0);
        check("cmd_ready_after_read", 32'(cmd_ready), 1);
        rd_mode = 0;
    endtask

    initial begin
        logic [2:0] b;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_bank_q", 32'(bank_q), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        check("idle_busy", 32'(busy), 0);

        // Fill the whole array so every later read has a known expectation.
        for (int k = 0; k < 8; k++)
            write_burst(1'b1, 3'(k), 6'd0, 6'd63, 1'b1, 8'd0, 1'b0);

        // Wrap within bank 5, then read back at full rate and under back-pressure.
        write_burst(1'b1, 3'd5, 6'h3E, 6'd3, 1'b0, 8'hA0, 1'b0);
        read_burst(1'b0, 3'd0, 6'h3E, 6'd3, 0);
        read_burst(1'b0, 3'd0, 6'h3E, 6'd3, 1);
        read_burst(1'b1, 3'd5, 6'h00, 6'd1, 0);
        read_burst(1'b1, 3'd4, 6'h3F, 6'd0, 0);

        // Reset on the second beat of an 8-beat write: only the first beat lands.
        send_cmd(1'b1, 1'b1, 3'd2, 6'd10, 6'd7, b);
        wr_valid = 1'b1;
        wr_data  = 8'hC0;
        check("wr_ready_first_beat", 32'(wr_ready), 1);
        model_mem[2 * 64 + 10]  = 8'hC0;
        model_perr[2 * 64 + 10] = 1'b0;
        @(negedge clk);
        wr_data = 8'hC1;
        rst     = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 32'(cmd_ready), 0);
        check("midrst_wr_ready", 32'(wr_ready), 0);
        check("midrst_rd_valid", 32'(rd_valid), 0);
        check("midrst_bank_q", 32'(bank_q), 0);
        check("midrst_busy", 32'(busy), 0);
        rst        = 1'b0;
        wr_valid   = 1'b0;
        model_bank = 3'd0;
        @(negedge clk);
        check("postrst_cmd_ready", 32'(cmd_ready), 1);
        read_burst(1'b1, 3'd2, 6'd10, 6'd7, 2);

        // Randomised traffic with sticky-bank reuse and random stream stalls.
        for (int k = 0; k < 40; k++) begin
            wr_rand = 1'($urandom % 2);
            if ($urandom % 2 == 0)
                write_burst(1'($urandom % 3 != 0), 3'($urandom), 6'($urandom),
                            6'($urandom_range(0, 15)), 1'b1, 8'd0, 1'b0);
            else
                read_burst(1'($urandom % 3 != 0), 3'($urandom), 6'($urandom),
                           6'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end
        wr_rand = 1'b0;

`ifdef BANKED_SRAM_PARITY_EN
        write_burst(1'b1, 3'd7, 6'd5, 6'd0, 1'b0, 8'h55, 1'b1);
        read_burst(1'b0, 3'd0, 6'd5, 6'd0, 0);
        write_burst(1'b1, 3'd7, 6'd5, 6'd0, 1'b0, 8'h55, 1'b0);
        read_burst(1'b0, 3'd0, 6'd5, 6'd0, 0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/banked_sram_burst.md
# banked_sram_burst

Parametrised, single-port, banked on-chip SRAM with a valid/ready command channel and burst reads and writes.
- A command selects a bank (or reuses the sticky bank register), a start offset and a beat count.
- Write beats are taken from a write stream; read beats go out on a registered, back-pressurable read stream.
- It is the successor to the team's 512×8 direct-access demo memory and sits between the pin-level I/O adapter and the storage array.

## Interface
Parameters:
- DATA_W, 8, word width
- LO_W, 6, in-bank offset width; bank depth = 2**LO_W
- BANK_W, 3, bank index width; total depth = 2**(BANK_W+LO_W)
- LEN_W, 6, burst length field width; a burst is cmd_len+1 beats

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_bank_sel  in  1  1 = use cmd_bank and load the bank register
- cmd_bank  in  BANK_W  explicit bank
- cmd_addr  in  LO_W  start offset
- cmd_len  in  LEN_W  beats minus one
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_W  write beat
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_W  read beat (registered)
- bank_q  out  BANK_W  current sticky bank register
- busy  out  1  high in any state other than IDLE

## Operation
FSM states are IDLE, WRITE, READ and DRAIN.

- **IDLE**
  - cmd_ready=1.
  - On command handshake:
    - bank = cmd_bank_sel ? cmd_bank : bank_q.
    - If cmd_bank_sel, bank_q<=cmd_bank.
    - ptr<={bank,cmd_addr}, rem<=cmd_len.
    - Next state is WRITE if cmd_we, otherwise READ.
- **WRITE**
  - wr_ready=1.
  - Each wr_valid&&wr_ready beat: mem[ptr]<=wr_data and the offset increments.
  - On the beat with rem==0: go to IDLE; otherwise rem decrements.
- **READ**
  - A read is issued when !rd_valid || rd_ready. rd_data<=mem[ptr] at that edge, rd_valid<=1, offset increments, rem decrements.
  - Issuing the rem==0 beat moves the FSM to DRAIN.
- **DRAIN**
  - Hold rd_valid/rd_data until rd_ready, then rd_valid<=0 and go to IDLE.
  - A command is never accepted while a read beat is pending.
- **Offset wrap**
  - Only the LO_W offset increments, modulo 2**LO_W. The bank never changes within a burst.
  - Example: offset 63 with LO_W=6 → next offset 0, same bank.
- **Stream rules**
  - rd_valid, once high, stays high with rd_data stable until accepted.
  - wr_ready and cmd_ready are never high simultaneously.
- **Reset** (any state, including mid-burst)
  - FSM→IDLE, rd_valid=0, rd_data=0, bank_q=0, ptr=0, rem=0.
  - Memory contents are not cleared.
  - The remainder of an interrupted write burst is dropped.
- **Reset output values:** cmd_ready=0 during rst, then 1; wr_ready=0; rd_valid=0; rd_data=0; bank_q=0; busy=0.

## Timing
- Write: the beat is stored at the edge where wr_valid&&wr_ready. The first beat may arrive the cycle after the command handshake.
- Read latency: rd_valid rises 2 edges after the command handshake edge (edge 1 enters READ, edge 2 registers the data).
- Throughput: 1 beat/cycle in both directions while the stream partner keeps valid/ready high.
- Command turnaround:
  - After a write burst: cmd_ready 1 cycle after the last write beat.
  - After a read burst: 1 cycle after the last rd handshake.
- Write-then-read of the same address in consecutive bursts returns the new data. There are no bypass hazards, because the array is single-port and accesses are serialised.

## Configuration
- Macro: BANKED_SRAM_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits, the extra bit being the even parity of the data written.
  - Output port rd_perr (1 bit) is added. It is registered alongside rd_data, high when the stored parity does not match the read data, and 0 on reset.
  - The test hook port err_inj (in, 1) inverts the stored parity bit on write.
- Undefined: no parity storage, no rd_perr or err_inj ports, and the array is DATA_W bits wide.

## Structure
- Package banked_sram_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN);
  - a localparam-style function giving ADDR_W = BANK_W+LO_W;
  - the parity helper function.
- Sub-module sram_array:
  - single-port synchronous array, parametrised width/depth;
  - one write or one read per cycle, read data registered;
  - isolates the storage so a hard macro can replace it later.
- The top level holds the FSM, the pointer/remaining counters, bank_q and the stream handshakes.

## Test plan
- Reset, then a write burst with bank_sel=1, bank=5, addr=0x3E, len=3, data A0..A3 → addresses 5:3E, 5:3F, 5:00, 5:01 (wrap within the bank). bank_q=5; busy drops 1 cycle after the 4th beat.
- Read burst with bank_sel=0, addr=0x3E, len=3, rd_ready always 1 → rd_data A0,A1,A2,A3 on consecutive cycles. The first rd_valid comes 2 edges after the command handshake.
- Same read with rd_ready toggling 1,0,0,1,... → no beat lost or duplicated, rd_data stable while stalled, cmd_ready low until the last beat is accepted.
- rst asserted during the 2nd beat of a len=7 write → IDLE next cycle, bank_q=0, rd_valid=0. A subsequent read returns the beat already written and old contents elsewhere.
- With BANKED_SRAM_PARITY_EN: write 0x55 with err_inj=1, then read it back → rd_perr=1 with rd_data=0x55. The same test without err_inj → rd_perr=0.
